sme_stream_driver: RTL and testbench

//  Upstream sequencer for the string-matching engine. Accepts tagged host bytes (string or pattern bursts)

---
 rtl/sme_stream_driver_if.sv | 23 ++
 rtl/sme_stream_driver.sv | 176 +++++++++++++++++
 tb/tb_sme_stream_driver.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sme_stream_driver_if.sv
// Host-side bundle for sme_stream_driver: tagged byte input stream and per-pattern result return.
interface sme_stream_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_kind;
  logic       in_last;
  logic       res_valid;
  logic       res_ready;
  logic       res_match;
  logic [4:0] res_index;
  logic [7:0] res_seq;

  modport master (
    output in_valid, in_data, in_kind, in_last, res_ready,
    input  in_ready, res_valid, res_match, res_index, res_seq
  );

  modport slave (
    input  in_valid, in_data, in_kind, in_last, res_ready,
    output in_ready, res_valid, res_match, res_index, res_seq
  );
endinterface

// File: rtl/sme_stream_driver.sv
// Buffers one host burst, replays it to the string-matching engine as a contiguous strobe run,
// and returns the engine's match result for every pattern burst.
module sme_stream_driver #(
  parameter int BUF_MAX = 32,
  parameter int GAP     = 1,
  parameter int RES_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  sme_stream_driver_if.slave   host,
  output logic [7:0]           chardata_o,
  output logic                 isstring_o,
  output logic                 ispattern_o,
  input  logic                 sme_match_i,
  input  logic [4:0]           sme_match_index_i,
  output logic                 busy_o,
  output logic                 err_ovf_o
);

  localparam int PTR_W   = $clog2(BUF_MAX + 1);
  localparam int RD_W    = (BUF_MAX > 1) ? $clog2(BUF_MAX) : 1;
  localparam int CNT_MAX = (GAP > RES_LAT) ? GAP : RES_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_PLAY   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kind_q, kind_d;
  logic             err_ovf_q, err_ovf_d;
  logic             res_match_q, res_match_d;
  logic [4:0]       res_index_q, res_index_d;
  logic [7:0]       res_seq_q, res_seq_d;

  logic [7:0]       buf_q [BUF_MAX];
  logic             buf_we;
  logic [RD_W-1:0]  buf_waddr;

  logic             in_ready;
  logic             play;
  logic             last_byte;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign play      = (state_q == S_PLAY);
  // wr_q holds the burst length, so the final replayed byte sits at wr_q-1.
  assign last_byte = (PTR_W'(rd_q) + PTR_W'(1)) == wr_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    kind_d      = kind_q;
    err_ovf_d   = err_ovf_q;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    res_seq_d   = res_seq_q;
    buf_we      = 1'b0;
    buf_waddr   = '0;

    case (state_q)
      S_IDLE: begin
        if (host.in_valid) begin
          buf_we  = 1'b1;
          wr_d    = PTR_W'(1);
          rd_d    = '0;
          kind_d  = host.in_kind;
          state_d = host.in_last ? S_PLAY : S_LOAD;
        end
      end
      S_LOAD: begin
        if (host.in_valid) begin
          if (wr_q < PTR_W'(BUF_MAX)) begin
            buf_we    = 1'b1;
            buf_waddr = wr_q[RD_W-1:0];
            wr_d      = wr_q + PTR_W'(1);
          end else begin
            err_ovf_d = 1'b1;
          end
          if (host.in_last) begin
            rd_d    = '0;
            state_d = S_PLAY;
          end
        end
      end
      S_PLAY: begin
        if (last_byte) begin
          cnt_d   = CNT_W'(1);
          state_d = S_GAP;
        end else begin
          rd_d = rd_q + RD_W'(1);
        end
      end
      S_GAP, S_WAIT: begin
        // cnt_q counts cycles since the last strobe, so the capture lands exactly RES_LAT after it.
        cnt_d = cnt_q + CNT_W'(1);
        if (kind_q && (cnt_q == CNT_W'(RES_LAT))) begin
          res_match_d = sme_match_i;
          res_index_d = sme_match_index_i;
        end
        if (state_q == S_GAP) begin
          if (cnt_q == CNT_W'(GAP)) begin
            if (!kind_q) begin
              state_d   = S_IDLE;
              res_seq_d = '0;
            end else if (RES_LAT <= GAP) begin
              state_d = S_RESULT;
            end else begin
              state_d = S_WAIT;
            end
          end
        end else if (cnt_q == CNT_W'(RES_LAT)) begin
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (host.res_ready) begin
          state_d   = S_IDLE;
          res_seq_d = res_seq_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      kind_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
      res_seq_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      kind_q      <= kind_d;
      err_ovf_q   <= err_ovf_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      res_seq_q   <= res_seq_d;
    end
  end

  // NOTE: the burst buffer is not reset; wr_q/rd_q gate every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[buf_waddr] <= host.in_data;
  end

  assign host.in_ready  = in_ready;
  assign host.res_valid = (state_q == S_RESULT);
  assign host.res_match = res_match_q;
  assign host.res_index = res_index_q;
  assign host.res_seq   = res_seq_q;

  assign chardata_o  = play ? buf_q[rd_q] : 8'h00;
  assign isstring_o  = play && !kind_q;
  assign ispattern_o = play && kind_q;
  assign busy_o      = (state_q != S_IDLE);
  assign err_ovf_o   = err_ovf_q;

endmodule

// File: tb/tb_sme_stream_driver.sv
// Self-checking bench for sme_stream_driver: burst table, directed corner sequences and random bursts
// scored against a byte/result queue model with an engine stub whose outputs are a known function of time.
module tb_sme_stream_driver;
  localparam int BUF_MAX = 32;
  localparam int GAP     = 1;
  localparam int RES_LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       sme_match;
  logic [4:0] sme_match_index;
  logic       busy, err_ovf;

  sme_stream_driver_if host ();

  sme_stream_driver #(.BUF_MAX(BUF_MAX), .GAP(GAP), .RES_LAT(RES_LAT)) dut (
    .clk               (clk),
    .reset             (reset),
    .host              (host),
    .chardata_o        (chardata),
    .isstring_o        (isstring),
    .ispattern_o       (ispattern),
    .sme_match_i       (sme_match),
    .sme_match_index_i (sme_match_index),
    .busy_o            (busy),
    .err_ovf_o         (err_ovf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] d; logic k; } xb_t;
  typedef struct { logic m; logic [4:0] i; logic [7:0] s; } res_t;

  xb_t  exp_bytes [$];
  int   exp_len   [$];
  int   exp_seq_q [$];
  res_t exp_res   [$];
  int   model_seq = 0;
  bit   model_ovf = 1'b0;
  bit   sb_en     = 1'b1;

  logic [7:0] tx [64];

  function automatic logic hash_m(input int n);
    return n[1] ^ n[3];
  endfunction

  function automatic logic [4:0] hash_i(input int n);
    return 5'((n * 5 + 3) & 31);
  endfunction

  // ---------------- monitor / engine stub / result consumer ----------------
  int         cyc = 0;
  int         stub_mode = 0;   // 0: time hash, 1: match=1,index=1 only RES_LAT after the last pattern byte
  int         rr_mode   = 1;   // 0: random, 1: always ready, 2: stalled
  logic [7:0] phist = '0;
  bit         run_act = 1'b0, run_seen = 1'b0;
  int         run_len = 0, idle_cnt = 0;
  logic       run_kind = 1'b0;
  int         gap_viol = 0, cd_viol = 0, kind_viol = 0;
  int         run_count = 0, res_count = 0;
  int         last_run_len = 0;
  logic       last_run_kind = 1'b0;
  logic       last_res_m = 1'b0;
  logic [4:0] last_res_i = '0;
  logic [7:0] last_res_s = '0;
  xb_t        mon_e;
  res_t       mon_r;
  logic       hit;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      run_act = 1'b0;
      phist   = '0;
    end else begin
      if (isstring && ispattern) kind_viol++;
      if (isstring || ispattern) begin
        if (!run_act) begin
          if (run_seen && idle_cnt < GAP) gap_viol++;
          run_act  = 1'b1;
          run_len  = 0;
          run_kind = ispattern;
        end
        if (ispattern != run_kind) kind_viol++;
        run_len++;
        if (sb_en) begin
          check("sb_byte_expected", exp_bytes.size() > 0, 1);
          if (exp_bytes.size() > 0) begin
            mon_e = exp_bytes.pop_front();
            check("replay_byte", chardata, mon_e.d);
            check("replay_kind", ispattern, mon_e.k);
          end
        end
      end else begin
        if (chardata != 8'h00) cd_viol++;
        if (run_act) begin
          // the run's last strobe was the previous cycle
          run_act       = 1'b0;
          run_seen      = 1'b1;
          idle_cnt      = 0;
          run_count++;
          last_run_len  = run_len;
          last_run_kind = run_kind;
          if (sb_en) begin
            check("sb_run_expected", exp_len.size() > 0, 1);
            if (exp_len.size() > 0) check("run_len", run_len, exp_len.pop_front());
            if (run_kind && exp_seq_q.size() > 0) begin
              mon_r.s = 8'(exp_seq_q.pop_front());
              mon_r.m = (stub_mode == 1) ? 1'b1 : hash_m(cyc - 1 + RES_LAT);
              mon_r.i = (stub_mode == 1) ? 5'd1 : hash_i(cyc - 1 + RES_LAT);
              exp_res.push_back(mon_r);
            end
          end
        end
        idle_cnt++;
      end
      phist = {phist[6:0], ispattern};
    end

    if (stub_mode == 0) begin
      sme_match       = hash_m(cyc);
      sme_match_index = hash_i(cyc);
    end else begin
      hit             = phist[RES_LAT] && !phist[RES_LAT-1];
      sme_match       = hit;
      sme_match_index = hit ? 5'd1 : 5'd0;
    end

    case (rr_mode)
      0:       host.res_ready = 1'($urandom_range(0, 1));
      1:       host.res_ready = 1'b1;
      default: host.res_ready = 1'b0;
    endcase
    if (!reset && host.res_valid && host.res_ready) begin
      res_count++;
      last_res_m = host.res_match;
      last_res_i = host.res_index;
      last_res_s = host.res_seq;
      if (sb_en) begin
        check("sb_result_expected", exp_res.size() > 0, 1);
        if (exp_res.size() > 0) begin
          mon_r = exp_res.pop_front();
          check("res_match", host.res_match, mon_r.m);
          check("res_index", host.res_index, mon_r.i);
          check("res_seq", host.res_seq, mon_r.s);
        end
      end
    end
  end

  // ---------------- host driver ----------------
  task automatic send_burst(input logic kind, input int len, input bit gaps);
    int n;
    int t;
    n = (len > BUF_MAX) ? BUF_MAX : len;
    for (int i = 0; i < n; i++) exp_bytes.push_back('{tx[i], kind});
    exp_len.push_back(n);
    if (len > BUF_MAX) model_ovf = 1'b1;
    if (kind) begin
      exp_seq_q.push_back(model_seq);
      model_seq = (model_seq + 1) % 256;
    end else begin
      model_seq = 0;
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (gaps && i > 0) begin
        host.in_valid = 1'b0;
        @(negedge clk);
      end
      host.in_valid = 1'b1;
      host.in_data  = tx[i];
      host.in_kind  = (i == 0) ? kind : ~kind;
      host.in_last  = (i == len - 1);
      t = 0;
      while (!host.in_ready && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 1000) begin
        check("in_ready_timeout", t, 0);
        host.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    host.in_valid = 1'b0;
    host.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((busy || exp_res.size() > 0 || exp_len.size() > 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", t < 3000, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic fill_tx(input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) tx[i] = base + 8'(i);
  endtask

  // ---------------- stimulus ----------------
  typedef struct { logic kind; int len; logic [7:0] base; int exp_play; int exp_seq; } vec_t;
  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    int   rc;
    int   seen;
    bit   stable;
    logic sm;
    logic [4:0] si;
    logic [7:0] ss;

    vecs[0] = '{1'b0,  3, 8'h61,  3, -1};  // "abc"
    vecs[1] = '{1'b1,  1, 8'h62,  1,  0};  // "b"
    vecs[2] = '{1'b1,  2, 8'h5e,  2,  1};
    vecs[3] = '{1'b0, 32, 8'h20, 32, -1};  // exactly full buffer, no overflow
    vecs[4] = '{1'b1,  5, 8'h41,  5,  0};
    vecs[5] = '{1'b1, 32, 8'h80, 32,  1};

    host.in_valid = 1'b0;
    host.in_data  = '0;
    host.in_kind  = 1'b0;
    host.in_last  = 1'b0;
    reset         = 1'b1;

    #12;
    check("rst_in_ready", host.in_ready, 1);
    check("rst_chardata", chardata, 0);
    check("rst_isstring", isstring, 0);
    check("rst_ispattern", ispattern, 0);
    check("rst_res_valid", host.res_valid, 0);
    check("rst_res_match", host.res_match, 0);
    check("rst_res_index", host.res_index, 0);
    check("rst_res_seq", host.res_seq, 0);
    check("rst_busy", busy, 0);
    check("rst_err_ovf", err_ovf, 0);
    @(negedge clk);
    #3 reset = 1'b0;

    // table of bursts
    for (int v = 0; v < 6; v++) begin
      fill_tx(vecs[v].base, vecs[v].len);
      rc = res_count;
      send_burst(vecs[v].kind, vecs[v].len, 1'b0);
      wait_drain();
      check("vec_play_len", last_run_len, vecs[v].exp_play);
      check("vec_play_kind", last_run_kind, vecs[v].kind);
      if (vecs[v].kind) check("vec_res_seq", last_res_s, vecs[v].exp_seq);
      else              check("vec_no_result", res_count, rc);
    end
    check("table_err_ovf", err_ovf, 0);

    // engine stub answers match=1,index=1 only at the exact capture cycle
    stub_mode = 1;
    fill_tx(8'h61, 3);
    send_burst(1'b0, 3, 1'b0);
    wait_drain();
    tx[0] = 8'h62;
    send_burst(1'b1, 1, 1'b0);
    wait_drain();
    check("stub_res_match", last_res_m, 1);
    check("stub_res_index", last_res_i, 1);
    check("stub_res_seq", last_res_s, 0);
    stub_mode = 0;

    // three patterns after one string, first result stalled 5 cycles
    fill_tx(8'h70, 4);
    send_burst(1'b0, 4, 1'b0);
    wait_drain();
    rr_mode = 2;
    fill_tx(8'h31, 2);
    send_burst(1'b1, 2, 1'b0);
    t = 0;
    while (!host.res_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("stall_res_valid", host.res_valid, 1);
    sm = host.res_match;
    si = host.res_index;
    ss = host.res_seq;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!host.res_valid || host.res_match != sm || host.res_index != si || host.res_seq != ss)
        stable = 1'b0;
    end
    check("stall_stable", stable, 1);
    check("stall_seq", ss, 0);
    rr_mode = 1;
    wait_drain();
    fill_tx(8'h40, 3);
    send_burst(1'b1, 3, 1'b0);
    send_burst(1'b1, 1, 1'b0);
    wait_drain();
    check("third_pattern_seq", last_res_s, 2);
    fill_tx(8'h61, 2);
    send_burst(1'b0, 2, 1'b0);
    send_burst(1'b1, 2, 1'b0);
    wait_drain();
    check("seq_after_new_string", last_res_s, 0);

    // 40-byte string overflows the 32-byte buffer
    check("pre_ovf_err", err_ovf, 0);
    for (int i = 0; i < 40; i++) tx[i] = 8'($urandom_range(32, 126));
    send_burst(1'b0, 40, 1'b0);
    wait_drain();
    check("ovf_play_len", last_run_len, 32);
    check("ovf_err_set", err_ovf, 1);
    fill_tx(8'h61, 2);
    send_burst(1'b1, 2, 1'b0);
    wait_drain();
    check("ovf_err_sticky", err_ovf, 1);

    // in_valid toggling during LOAD still gives one contiguous run
    fill_tx(8'h50, 10);
    send_burst(1'b1, 10, 1'b1);
    wait_drain();
    check("toggle_play_len", last_run_len, 10);

    // random bursts, back to back, random result back-pressure
    rr_mode = 0;
    for (int b = 0; b < 30; b++) begin
      int len;
      len = $urandom_range(1, 36);
      for (int i = 0; i < len; i++) tx[i] = 8'($urandom);
      send_burst(1'($urandom_range(0, 1)), len, 1'($urandom_range(0, 1)));
    end
    wait_drain();
    rr_mode = 1;
    check("rand_err_ovf", err_ovf, int'(model_ovf));
    check("rand_queues_empty", exp_bytes.size() + exp_len.size() + exp_res.size(), 0);

    // reset in the middle of PLAY
    sb_en = 1'b0;
    for (int i = 0; i < 20; i++) tx[i] = 8'(8'h5e + i);
    send_burst(1'b0, 20, 1'b0);
    @(negedge clk);
    check("pre_reset_play", isstring, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_isstring", isstring, 0);
    check("async_rst_ispattern", ispattern, 0);
    check("async_rst_chardata", chardata, 0);
    check("async_rst_in_ready", host.in_ready, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_res_valid", host.res_valid, 0);
    @(negedge clk);
    #3 reset = 1'b0;
    exp_bytes.delete();
    exp_len.delete();
    exp_seq_q.delete();
    exp_res.delete();
    model_seq = 0;
    model_ovf = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (isstring || ispattern || host.res_valid) seen++;
    end
    check("post_reset_quiet", seen, 0);
    check("post_reset_err_ovf", err_ovf, 0);
    sb_en = 1'b1;
    fill_tx(8'h62, 3);
    send_burst(1'b1, 3, 1'b0);
    wait_drain();
    check("post_reset_seq", last_res_s, 0);
    check("post_reset_play_len", last_run_len, 3);

    check("gap_violations", gap_viol, 0);
    check("idle_chardata_nonzero", cd_viol, 0);
    check("strobe_kind_violations", kind_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
